// File: rtl/m_clk_divider_pkg.sv
// Shared constants for the multi-channel clock divider.
package m_clk_divider_pkg;

    localparam int DEF_NCH      = 4;   // number of divider channels
    localparam int DEF_CW       = 16;  // half-period counter width
    localparam int DEF_HALF_CYC = 50;  // half-period loaded at reset
    localparam int CYC_W        = 32;  // free-running cycle counter width

endpackage

// File: rtl/m_clk_divider_ch.sv
// One divider channel: half-period register, counter, square-wave output and rise tick.
module m_clk_divider_ch
    import m_clk_divider_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int DEF_HALF = DEF_HALF_CYC
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    input  logic          w_we,
    input  logic [CW-1:0] w_half,
    input  logic          w_en,
    output logic          r_out,
    output logic          r_tick
);

    // A programmed half-period of zero behaves like one so the output never stalls.
    function automatic logic [CW-1:0] eff_half(input logic [CW-1:0] h);
        return (h == '0) ? CW'(1) : h;
    endfunction

    logic [CW-1:0] half;
    logic [CW-1:0] cnt;
    logic          term;

    assign term = (cnt == (eff_half(half) - CW'(1)));

    // Disable dominates, then a config write (restarts the count, holds the level), then counting.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            half   <= CW'(DEF_HALF);
            cnt    <= '0;
            r_out  <= 1'b0;
            r_tick <= 1'b0;
        end else if (!w_en) begin
            if (w_we) begin
                half <= w_half;
            end
            cnt    <= '0;
            r_out  <= 1'b0;
            r_tick <= 1'b0;
        end else if (w_we) begin
            half   <= w_half;
            cnt    <= '0;
            r_tick <= 1'b0;
        end else if (term) begin
            cnt    <= '0;
            r_out  <= ~r_out;
            r_tick <= ~r_out;
        end else begin
            cnt    <= cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/m_clk_divider.sv
// Multi-channel programmable clock divider with a free-running cycle counter.
module m_clk_divider
    import m_clk_divider_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int CW       = DEF_CW,
    parameter int DEF_HALF = DEF_HALF_CYC,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic             w_we,
    input  logic [CHW-1:0]   w_ch,
    input  logic [CW-1:0]    w_half,
    input  logic [NCH-1:0]   w_en,
    output logic [NCH-1:0]   r_out,
    output logic [NCH-1:0]   r_tick,
    output logic [CYC_W-1:0] r_cycles
);

    // Free-running cycle count since reset, wraps naturally.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + CYC_W'(1);
        end
    end

    // Writes addressing a nonexistent channel match no index and are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic sel;
        assign sel = w_we && (w_ch == CHW'(i));

        m_clk_divider_ch #(
            .CW       (CW),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .w_clk   (w_clk),
            .w_rst_n (w_rst_n),
            .w_we    (sel),
            .w_half  (w_half),
            .w_en    (w_en[i]),
            .r_out   (r_out[i]),
            .r_tick  (r_tick[i])
        );
    end

endmodule

// File: doc/m_clk_divider.md
M_CLK_DIVIDER -- requirements
Module: m_clk_divider

Interface
REQ-001 Parameters SHALL be: NCH, default 4, number of independent divider channels; CW, default 16, half-period counter width; DEF_HALF, default 50, half-period loaded at reset.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 Port w_clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port w_rst_n  input  1  synchronous active-low reset.
REQ-005 Port w_we  input  1  config write strobe, one-cycle.
REQ-006 Port w_ch  input  clog2(NCH) (min 1)  channel index for the write.
REQ-007 Port w_half  input  CW  half-period in cycles for the addressed channel.
REQ-008 Port w_en  input  NCH  per-channel run enable, level.
REQ-009 Port r_out  output  NCH  registered divided square wave per channel.
REQ-010 Port r_tick  output  NCH  one-cycle pulse per channel on each 0->1 transition of r_out.
REQ-011 Port r_cycles  output  32  free-running cycle count since reset.

Function
REQ-012 Each channel SHALL hold a half-period register half[i] (CW bits) and a counter cnt[i] (CW bits).
REQ-013 An effective half-period SHALL be used: eff = (half[i]==0) ? 1 : half[i].
REQ-014 When w_en[i]=1, cnt[i] SHALL increment each cycle; on cnt[i]==eff-1, cnt[i]->0 and r_out[i] toggles.
REQ-015 r_out[i] period SHALL be exactly 2*eff cycles, 50% duty; with DEF_HALF=50, period = 100 cycles.
REQ-016 r_tick[i] SHALL be 1 in exactly those cycles where r_out[i] has just become 1 (registered with the toggle), else 0.
REQ-017 When w_en[i]=0, cnt[i] SHALL go to 0, r_out[i] to 0, r_tick[i] to 0 on the next edge; half[i] is retained.
REQ-018 After w_en[i] rises, the first r_out[i] 0->1 SHALL occur eff cycles later (measured edge-to-edge from the first enabled edge, inclusive).
REQ-019 On w_we=1 with w_ch<NCH, half[w_ch] SHALL load w_half and cnt[w_ch] SHALL go to 0; r_out[w_ch] is unchanged; the new ratio applies from the next cycle.
REQ-020 A write with w_ch>=NCH SHALL be ignored, no state change.
REQ-021 A write and a terminal count on the same channel in the same cycle: the write SHALL win (cnt->0, no toggle, no tick).
REQ-022 A write while the channel is disabled SHALL load half[i]; the channel stays at 0.
REQ-023 Channels SHALL be fully independent; a write to one channel SHALL not disturb any other.
REQ-024 r_cycles SHALL increment by 1 every cycle with w_rst_n=1 and wrap from 2^32-1 to 0.

Reset
REQ-025 While w_rst_n=0 at a rising edge: half[i]=DEF_HALF, cnt[i]=0, r_out=0, r_tick=0, r_cycles=0.
REQ-026 Reset SHALL override w_we and w_en in the same cycle.
REQ-027 Reset asserted mid-period SHALL abort the period; the first r_out 0->1 after release follows REQ-018.

Structure
REQ-028 A shared header SHALL hold the default constants (NCH, CW, DEF_HALF) and the 32-bit cycle-counter width.
REQ-029 A per-channel sub-module m_clk_divider_ch (half reg, counter, out, tick) SHALL be instantiated NCH times via generate; r_cycles lives in the top.

Verification
REQ-030 Reset, then w_en=4'b0001 with no writes -> r_out[0] high cycles 50..99, period 100; r_tick[0] pulses at cycles 50, 150, 250.
REQ-031 Write ch1 half=0, then enable -> r_out[1] toggles every cycle, period 2; r_tick[1] every 2nd cycle.
REQ-032 Ch2 half=3 running; write ch2 half=5 in the terminal-count cycle -> no toggle that cycle; next toggle 5 cycles later; period 10 thereafter.
REQ-033 Drop w_en[0] while r_out[0]=1 -> r_out[0]=0 next cycle, no tick; re-enable -> first rise after eff cycles.
REQ-034 Write with w_ch=NCH (NCH non-power-of-2 build, e.g. NCH=3) -> all half[] unchanged; assert w_rst_n=0 mid-run -> all outputs 0 and r_cycles=0 next cycle.
REQ-035 Preload r_cycles near wrap (force or long run) -> 0xFFFFFFFF followed by 0x00000000.
